mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single-ported synchronous data memory between instruction fetch (IF) and the
//  execute-stage load/store path (LS). Grants at most one request per cycle, registers the
//  winning access onto the memory port and routes read data back to its owner two cycles
//  after grant. Sits between the IF/EX stages and the memory; a branch from EX flushes
//  in-flight fetches.
// PARAMETERS
//  AW          16  address width (matches `ADDR)
//  DW          32  data width (matches `WORD)
//  STARVE_MAX  4   consecutive IF denials before IF is forced to win (fixed-priority mode)
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst          in   1   synchronous reset, active-high
//  if_req_i     in   1   IF read request; held with if_addr_i until granted
//  if_addr_i    in   AW  IF read address
//  if_flush_i   in   1   EX branch taken: discard IF responses in flight
//  if_gnt_o     out  1   IF request accepted this cycle (combinational)
//  if_rvalid_o  out  1   IF read data valid
//  if_rdata_o   out  DW  IF read data
//  ls_req_i     in   1   LS request; held with we/addr/wdata until granted
//  ls_we_i      in   1   1 = store, 0 = load
//  ls_addr_i    in   AW  LS address
//  ls_wdata_i   in   DW  store data
//  ls_gnt_o     out  1   LS request accepted this cycle (combinational)
//  ls_rvalid_o  out  1   load data valid (never for stores)
//  ls_rdata_o   out  DW  load data
//  mem_en_o     out  1   memory access enable (registered)
//  mem_we_o     out  1   memory write enable (registered)
//  mem_addr_o   out  AW  memory address (registered)
//  mem_wdata_o  out  DW  memory write data (registered)
//  mem_rdata_i  in   DW  memory read data, valid cycle after mem_en_o && !mem_we_o
// BEHAVIOUR
//  - Reset: all mem_* regs, gnt/rvalid outputs, starvation counter, RR pointer, response
//    tag pipe = 0. rdata outputs are don't-care when rvalid = 0 (drive mem_rdata_i).
//  - Timing: grant in cycle N -> mem_* driven during N+1 -> rvalid/rdata during N+2.
//    Full throughput: one grant per cycle, back-to-back, no bubbles.
//  - Grant only when requesting; if_gnt_o and ls_gnt_o never both 1. No request ->
//    mem_en_o = 0 next cycle, mem_we_o = 0, other mem_* hold.
//  - Fixed priority: LS beats IF, except when starve_cnt == STARVE_MAX, then IF wins once.
//    starve_cnt increments each cycle IF requests and is denied (saturates at STARVE_MAX);
//    clears on IF grant or when if_req_i = 0.
//  - Response tag pipe: 2 stages of {owner, is_read, live}; rvalid_o of owner asserted only
//    if live && is_read at stage 2. Stores produce no response.
//  - Flush: if_flush_i in cycle N clears live on every IF tag in the pipe, including an IF
//    grant made in cycle N. IF responses returning in N+1 and N+2 suppressed. Memory reads
//    still execute (harmless). LS tags unaffected. IF grant in N+1 is live.
//  - Reset mid-operation: in-flight tags dropped; no rvalid in the two cycles after reset
//    even if memory returns data; mem_en_o = 0 the cycle after reset asserted.
//  - A requester dropping req before gnt is legal; no access issued for it.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: pure round-robin; last winner gets lowest priority on next
//    conflict; RR pointer resets to favour LS; starve_cnt not built; STARVE_MAX ignored.
//  Not defined: fixed LS priority with starvation counter as above.
// TESTING
//  - IF only, addr 0x0010 in cycle 1 -> if_gnt_o=1 c1, mem_en_o=1/addr 0x0010 c2,
//    if_rvalid_o=1 with memory word c3.
//  - LS store 0x0020<-0xDEADBEEF and IF read same cycle -> LS granted, mem_we_o=1 next
//    cycle, no ls_rvalid; IF granted following cycle; later load 0x0020 returns 0xDEADBEEF.
//  - LS requests every cycle, IF held: IF denied 4 cycles, granted in 5th, starve_cnt->0
//    (RR_EN build: strict alternation LS,IF,LS,IF).
//  - IF grants c1,c2,c3, if_flush_i in c3 -> no if_rvalid_o c3..c5; new IF grant c4 ->
//    if_rvalid_o c6.
//  - Load granted c1, rst high c2 -> no ls_rvalid_o c3, mem_en_o=0 c3, outputs all 0.
//  - Alternating IF/LS loads back-to-back 8 cycles -> each rvalid on correct port, in order,
//    data matching addressed words, no dropped or duplicated responses.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported synchronous memory between instruction
// fetch (IF) and the load/store path (LS). One grant per cycle. The winning access is
// registered onto the memory port, and read data returns to its owner two cycles after
// the grant.
// Build option MEM_ARB_RR_EN: when defined, arbitration is round-robin and there is no
// starvation counter. When undefined (the default), LS has fixed priority and a
// starvation counter guarantees that IF eventually wins.
module mem_port_arbiter #(
  parameter int AW         = 16,
  parameter int DW         = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  input  logic          if_flush_i,
  output logic          if_gnt_o,
  output logic          if_rvalid_o,
  output logic [DW-1:0] if_rdata_o,
  input  logic          ls_req_i,
  input  logic          ls_we_i,
  input  logic [AW-1:0] ls_addr_i,
  input  logic [DW-1:0] ls_wdata_i,
  output logic          ls_gnt_o,
  output logic          ls_rvalid_o,
  output logic [DW-1:0] ls_rdata_o,
  output logic          mem_en_o,
  output logic          mem_we_o,
  output logic [AW-1:0] mem_addr_o,
  output logic [DW-1:0] mem_wdata_o,
  input  logic [DW-1:0] mem_rdata_i
);

  // One tag travels with each granted access until its data returns.
  typedef struct packed {
    logic owner_ls;  // 1 = LS owns the access, 0 = IF owns it
    logic is_read;   // only reads produce a response
    logic live;      // cleared by a flush (IF tags only) or by reset
  } tag_t;

  logic          if_win;
  logic          ls_win;
  tag_t          tag1_q, tag1_d;
  tag_t          tag2_q, tag2_d;
  logic          mem_en_q;
  logic          mem_we_q;
  logic [AW-1:0] mem_addr_q;
  logic [DW-1:0] mem_wdata_q;

`ifdef MEM_ARB_RR_EN
  // Set when LS won the most recent grant. On the next conflict this favours IF.
  // Reset leaves it clear, so LS wins the first conflict.
  logic last_ls_q;

  // Round-robin choice: on a conflict, the side that did not win last time gets the grant.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (!rst) begin
      if (if_req_i && ls_req_i) begin
        if (last_ls_q) begin
          if_win = 1'b1;
        end else begin
          ls_win = 1'b1;
        end
      end else begin
        if_win = if_req_i;
        ls_win = ls_req_i;
      end
    end
  end

  // Remember which side won the most recent grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_ls_q <= 1'b0;
    end else if (ls_win) begin
      last_ls_q <= 1'b1;
    end else if (if_win) begin
      last_ls_q <= 1'b0;
    end
  end
`else
  localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [CW-1:0] STARVE_LIMIT = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt_q;
  logic          if_forced;

  assign if_forced = (starve_cnt_q == STARVE_LIMIT);

  // LS has priority unless IF has been denied often enough to force one IF win.
  always_comb begin
    if_win = 1'b0;
    ls_win = 1'b0;
    if (!rst) begin
      if_win = if_req_i && (!ls_req_i || if_forced);
      ls_win = ls_req_i && !if_win;
    end
  end

  // Count consecutive cycles in which IF requested but was denied. The count saturates
  // at the limit and clears when IF is granted or stops requesting.
  always_ff @(posedge clk) begin
    if (rst || !if_req_i || if_win) begin
      starve_cnt_q <= '0;
    end else if (starve_cnt_q != STARVE_LIMIT) begin
      starve_cnt_q <= starve_cnt_q + CW'(1);
    end
  end
`endif

  // Register the winning access onto the memory port. Address and data hold when idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      mem_en_q <= if_win || ls_win;
      mem_we_q <= ls_win && ls_we_i;
      if (ls_win) begin
        mem_addr_q  <= ls_addr_i;
        mem_wdata_q <= ls_wdata_i;
      end else if (if_win) begin
        mem_addr_q <= if_addr_i;
      end
    end
  end

  // Build the next tags. A flush kills the IF grant made in the same cycle and any IF
  // tag already in stage 1.
  always_comb begin
    tag1_d          = '0;
    tag1_d.owner_ls = ls_win;
    tag1_d.is_read  = if_win || (ls_win && !ls_we_i);
    tag1_d.live     = (if_win && !if_flush_i) || ls_win;
    tag2_d          = tag1_q;
    if (if_flush_i && !tag1_q.owner_ls) begin
      tag2_d.live = 1'b0;
    end
  end

  // Two-stage response tag pipe. Reset drops everything in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag1_q <= '0;
      tag2_q <= '0;
    end else begin
      tag1_q <= tag1_d;
      tag2_q <= tag2_d;
    end
  end

  assign if_gnt_o    = if_win;
  assign ls_gnt_o    = ls_win;
  // A flush also hides the IF response that is returning in the same cycle.
  assign if_rvalid_o = !rst && tag2_q.live && tag2_q.is_read && !tag2_q.owner_ls && !if_flush_i;
  assign ls_rvalid_o = !rst && tag2_q.live && tag2_q.is_read && tag2_q.owner_ls;
  assign if_rdata_o  = mem_rdata_i;
  assign ls_rdata_o  = mem_rdata_i;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives directed and random traffic into mem_port_arbiter, with a
// synchronous RAM attached. Every cycle, the DUT outputs are compared against a
// request/response model. The model keeps a shadow memory and a queue of expected
// responses.
module tb_mem_port_arbiter;
  localparam int AW = 16;
  localparam int DW = 32;
  localparam int STARVE_MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i, if_flush_i, ls_req_i, ls_we_i;
  logic [AW-1:0] if_addr_i, ls_addr_i;
  logic [DW-1:0] ls_wdata_i;
  logic          if_gnt_o, if_rvalid_o, ls_gnt_o, ls_rvalid_o;
  logic [DW-1:0] if_rdata_o, ls_rdata_o;
  logic          mem_en_o, mem_we_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_wdata_o;
  logic [DW-1:0] mem_rdata_i;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_flush_i(if_flush_i),
    .if_gnt_o(if_gnt_o), .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i),
    .ls_gnt_o(ls_gnt_o), .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM.
  logic [DW-1:0] ram [0:65535];
  logic [DW-1:0] ram_rdata = '0;
  always @(posedge clk) begin
    if (mem_en_o === 1'b1) begin
      if (mem_we_o === 1'b1) ram[mem_addr_o] <= mem_wdata_o;
      else ram_rdata <= ram[mem_addr_o];
    end
  end
  assign mem_rdata_i = ram_rdata;

  function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
    return {a, ~a};
  endfunction

  // ---------------- model state ----------------
  typedef struct {
    int            due;
    bit            is_if;
    logic [DW-1:0] data;
    bit            live;
  } resp_t;

  logic [DW-1:0] shadow [0:65535];
  resp_t         pend[$];
  int            m_starve = 0;
  bit            m_last_ls = 1'b0;
  bit            m_known = 1'b0;
  bit            m_mem_en = 1'b0, m_mem_we = 1'b0;
  logic [AW-1:0] m_mem_addr = '0;
  logic [DW-1:0] m_mem_wdata = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Snapshot of the DUT outputs for the cycle just checked.
  logic          s_if_gnt, s_ls_gnt, s_if_rv, s_ls_rv, s_mem_en, s_mem_we;
  logic [AW-1:0] s_mem_addr;
  logic [DW-1:0] s_mem_wdata, s_if_rdata, s_ls_rdata;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  // Sample and check one cycle at the falling edge, advance the model, then return
  // just after the next rising edge, where the caller drives the next inputs.
  task automatic tick();
    bit            eg_if, eg_ls, ev_if, ev_ls;
    logic [DW-1:0] ed_if, ed_ls;
    resp_t         r;
    resp_t         keep[$];
    @(negedge clk);
    s_if_gnt = if_gnt_o;  s_ls_gnt = ls_gnt_o;
    s_if_rv = if_rvalid_o; s_ls_rv = ls_rvalid_o;
    s_mem_en = mem_en_o;  s_mem_we = mem_we_o;
    s_mem_addr = mem_addr_o; s_mem_wdata = mem_wdata_o;
    s_if_rdata = if_rdata_o; s_ls_rdata = ls_rdata_o;

    eg_if = 1'b0; eg_ls = 1'b0;
    if (!rst) begin
      if (if_req_i && ls_req_i) begin
`ifdef MEM_ARB_RR_EN
        if (m_last_ls) eg_if = 1'b1; else eg_ls = 1'b1;
`else
        if (m_starve >= STARVE_MAX) eg_if = 1'b1; else eg_ls = 1'b1;
`endif
      end else begin
        eg_if = if_req_i;
        eg_ls = ls_req_i;
      end
    end

    foreach (pend[i]) begin
      if (rst) pend[i].live = 1'b0;
      if (if_flush_i && pend[i].is_if && pend[i].due <= cyc + 2) pend[i].live = 1'b0;
    end
    ev_if = 1'b0; ev_ls = 1'b0; ed_if = '0; ed_ls = '0;
    foreach (pend[i]) begin
      if (pend[i].due == cyc && pend[i].live) begin
        if (pend[i].is_if) begin ev_if = 1'b1; ed_if = pend[i].data; end
        else begin ev_ls = 1'b1; ed_ls = pend[i].data; end
      end
    end

    chk("if_gnt", {31'b0, s_if_gnt}, {31'b0, eg_if});
    chk("ls_gnt", {31'b0, s_ls_gnt}, {31'b0, eg_ls});
    chk("if_rvalid", {31'b0, s_if_rv}, {31'b0, ev_if});
    chk("ls_rvalid", {31'b0, s_ls_rv}, {31'b0, ev_ls});
    if (ev_if) begin
      chk("if_rdata", s_if_rdata, ed_if);
      $display("cycle %0d: IF response %h", cyc, ed_if);
    end
    if (ev_ls) begin
      chk("ls_rdata", s_ls_rdata, ed_ls);
      $display("cycle %0d: LS response %h", cyc, ed_ls);
    end
    if (m_known) begin
      chk("mem_en", {31'b0, s_mem_en}, {31'b0, m_mem_en});
      chk("mem_we", {31'b0, s_mem_we}, {31'b0, m_mem_we});
      if (m_mem_en) chk("mem_addr", {16'b0, s_mem_addr}, {16'b0, m_mem_addr});
      if (m_mem_we) chk("mem_wdata", s_mem_wdata, m_mem_wdata);
    end

    if (rst) begin
      pend.delete();
      m_mem_en = 1'b0; m_mem_we = 1'b0; m_mem_addr = '0; m_mem_wdata = '0;
      m_starve = 0; m_last_ls = 1'b0; m_known = 1'b1;
    end else begin
      m_mem_en = eg_if || eg_ls;
      m_mem_we = eg_ls && ls_we_i;
      if (eg_ls) begin
        m_mem_addr = ls_addr_i;
        m_last_ls = 1'b1;
        if (ls_we_i) begin
          m_mem_wdata = ls_wdata_i;
          shadow[ls_addr_i] = ls_wdata_i;
        end else begin
          r.due = cyc + 2; r.is_if = 1'b0; r.data = shadow[ls_addr_i]; r.live = 1'b1;
          pend.push_back(r);
        end
      end else if (eg_if) begin
        m_mem_addr = if_addr_i;
        m_last_ls = 1'b0;
        r.due = cyc + 2; r.is_if = 1'b1; r.data = shadow[if_addr_i]; r.live = !if_flush_i;
        pend.push_back(r);
      end
      if (!if_req_i || eg_if) m_starve = 0;
      else if (m_starve < STARVE_MAX) m_starve++;
      foreach (pend[i]) if (pend[i].due > cyc) keep.push_back(pend[i]);
      pend = keep;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    if_req_i = 1'b0; ls_req_i = 1'b0; ls_we_i = 1'b0; if_flush_i = 1'b0; rst = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  int n_if, n_ls;
  bit exp_if;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      ram[i] = init_word(AW'(i));
      shadow[i] = init_word(AW'(i));
    end
    rst = 1'b1; if_req_i = 1'b0; if_flush_i = 1'b0; ls_req_i = 1'b0; ls_we_i = 1'b0;
    if_addr_i = '0; ls_addr_i = '0; ls_wdata_i = '0;
    tick();
    tick();
    chk("reset_mem_en", {31'b0, s_mem_en}, 32'd0);
    chk("reset_if_rvalid", {31'b0, s_if_rv}, 32'd0);
    idle(3);

    // IF-only fetch: grant, then memory access, then data.
    if_req_i = 1'b1; if_addr_i = 16'h0010; tick();
    chk("t1_if_gnt", {31'b0, s_if_gnt}, 32'd1);
    if_req_i = 1'b0; tick();
    chk("t1_mem_en", {31'b0, s_mem_en}, 32'd1);
    chk("t1_mem_addr", {16'b0, s_mem_addr}, 32'h0000_0010);
    tick();
    chk("t1_if_rvalid", {31'b0, s_if_rv}, 32'd1);
    chk("t1_if_rdata", s_if_rdata, 32'h0010_FFEF);

    // Store and fetch in the same cycle: LS first. The store gives no response, then a
    // load reads the stored word back.
    ls_req_i = 1'b1; ls_we_i = 1'b1; ls_addr_i = 16'h0020; ls_wdata_i = 32'hDEADBEEF;
    if_req_i = 1'b1; if_addr_i = 16'h0030; tick();
    chk("t2_ls_gnt", {31'b0, s_ls_gnt}, 32'd1);
    chk("t2_if_denied", {31'b0, s_if_gnt}, 32'd0);
    ls_req_i = 1'b0; ls_we_i = 1'b0; tick();
    chk("t2_if_gnt", {31'b0, s_if_gnt}, 32'd1);
    chk("t2_mem_we", {31'b0, s_mem_we}, 32'd1);
    chk("t2_mem_wdata", s_mem_wdata, 32'hDEADBEEF);
    if_req_i = 1'b0; ls_req_i = 1'b1; ls_addr_i = 16'h0020; tick();
    chk("t2_load_gnt", {31'b0, s_ls_gnt}, 32'd1);
    chk("t2_store_no_rvalid", {31'b0, s_ls_rv}, 32'd0);
    ls_req_i = 1'b0; tick();
    chk("t2_if_rdata", s_if_rdata, 32'h0030_FFCF);
    tick();
    chk("t2_ls_rvalid", {31'b0, s_ls_rv}, 32'd1);
    chk("t2_ls_rdata", s_ls_rdata, 32'hDEADBEEF);
    idle(3);

    // Contention: LS every cycle, with IF held.
    if_req_i = 1'b1; if_addr_i = 16'h0040; tick();
    ls_req_i = 1'b1; ls_we_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      ls_addr_i = AW'(16'h0080 + k);
`ifdef MEM_ARB_RR_EN
      exp_if = (k % 2) == 1;
`else
      exp_if = (k == 4);
`endif
      tick();
      chk("t3_if_gnt", {31'b0, s_if_gnt}, {31'b0, exp_if});
      chk("t3_ls_gnt", {31'b0, s_ls_gnt}, {31'b0, !exp_if});
    end
    idle(3);

    // A flush in the third of three fetches hides their responses, but the next fetch
    // is live.
    if_req_i = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      if_addr_i = AW'(16'h0050 + k); if_flush_i = (k == 3); tick();
      chk("t4_if_gnt", {31'b0, s_if_gnt}, 32'd1);
    end
    chk("t4_rv_c3", {31'b0, s_if_rv}, 32'd0);
    if_flush_i = 1'b0; if_addr_i = 16'h0060; tick();
    chk("t4_rv_c4", {31'b0, s_if_rv}, 32'd0);
    if_req_i = 1'b0; tick();
    chk("t4_rv_c5", {31'b0, s_if_rv}, 32'd0);
    tick();
    chk("t4_rv_c6", {31'b0, s_if_rv}, 32'd1);
    chk("t4_rdata_c6", s_if_rdata, 32'h0060_FF9F);
    idle(2);

    // Reset while a load is in flight.
    ls_req_i = 1'b1; ls_we_i = 1'b0; ls_addr_i = 16'h0020; tick();
    chk("t5_ls_gnt", {31'b0, s_ls_gnt}, 32'd1);
    ls_req_i = 1'b0; rst = 1'b1; tick();
    rst = 1'b0; tick();
    chk("t5_ls_rvalid", {31'b0, s_ls_rv}, 32'd0);
    chk("t5_mem_en", {31'b0, s_mem_en}, 32'd0);
    chk("t5_mem_addr", {16'b0, s_mem_addr}, 32'd0);
    chk("t5_mem_wdata", s_mem_wdata, 32'd0);
    tick();
    chk("t5_ls_rvalid_2", {31'b0, s_ls_rv}, 32'd0);
    idle(2);

    // Alternating IF/LS loads, back to back.
    n_if = 0; n_ls = 0;
    for (int k = 0; k < 11; k++) begin
      if (k < 8) begin
        if_req_i = (k % 2) == 0; ls_req_i = (k % 2) == 1; ls_we_i = 1'b0;
        if_addr_i = AW'(16'h0100 + k); ls_addr_i = AW'(16'h0200 + k);
      end else begin
        if_req_i = 1'b0; ls_req_i = 1'b0;
      end
      tick();
      if (s_if_rv === 1'b1) n_if++;
      if (s_ls_rv === 1'b1) n_ls++;
    end
    chk("t6_if_count", 32'(n_if), 32'd4);
    chk("t6_ls_count", 32'(n_ls), 32'd4);

    // Random traffic. Requesters normally hold until granted but sometimes drop or change.
    for (int k = 0; k < 3000; k++) begin
      if (!if_req_i || s_if_gnt === 1'b1 || $urandom_range(0, 15) == 0) begin
        if_req_i = $urandom_range(0, 2) != 0;
        if_addr_i = AW'($urandom_range(0, 63));
      end
      if (!ls_req_i || s_ls_gnt === 1'b1 || $urandom_range(0, 15) == 0) begin
        ls_req_i = $urandom_range(0, 2) != 0;
        ls_we_i = $urandom_range(0, 2) == 0;
        ls_addr_i = AW'($urandom_range(0, 63));
        ls_wdata_i = $urandom;
      end
      if_flush_i = $urandom_range(0, 19) == 0;
      rst = $urandom_range(0, 99) == 0;
      tick();
    end
    idle(4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
